memi_arbiter: RTL and testbench

- Shares one memory-interface (memi) master port between NR_REQ requesters, e.g. the JTAG core debug port and a core-side agent.
- Round-robin arbitration; one transaction outstanding at a time; the grant is held until the slave signals ready or a timeout fires.
- Sits between the requesters and the memi slave fabric, all in the memi_clk domain.

---
 rtl/memi_arbiter.sv | 151 +++++++++++++++
 tb/tb_memi_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memi_arbiter.sv
// Round-robin arbiter that shares one memi master port between NR_REQ requesters.
// One transaction is in flight at a time; the grant holds until memi_ready or a timeout abort.
module memi_arbiter #(
  parameter int NR_REQ           = 2,
  parameter int MEMI_NR_SLAVES   = 1,
  parameter int MEMI_ADDR_WIDTH  = 5,
  parameter int MEMI_WDATA_WIDTH = 32,
  parameter int MEMI_RDATA_WIDTH = 32,
  parameter int TIMEOUT          = 255
) (
  input  logic                                 memi_clk,
  input  logic                                 memi_rst,
  input  logic [NR_REQ-1:0]                    req_valid,
  input  logic [NR_REQ*MEMI_ADDR_WIDTH-1:0]    req_addr,
  input  logic [NR_REQ*MEMI_NR_SLAVES-1:0]     req_sel,
  input  logic [NR_REQ-1:0]                    req_wr_rd,
  input  logic [NR_REQ*MEMI_WDATA_WIDTH-1:0]   req_wdata,
  output logic [NR_REQ-1:0]                    req_ack,
  output logic [NR_REQ-1:0]                    req_err,
  output logic [MEMI_RDATA_WIDTH-1:0]          req_rdata,
  output logic                                 busy,
  output logic [MEMI_ADDR_WIDTH-1:0]           memi_addr,
  output logic [MEMI_NR_SLAVES-1:0]            memi_sel,
  output logic                                 memi_wr_rd,
  output logic [MEMI_WDATA_WIDTH-1:0]          memi_wdata,
  input  logic [MEMI_RDATA_WIDTH-1:0]          memi_rdata,
  input  logic                                 memi_ready
);

  localparam int IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NR_REQ - 1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              ptr_q, ptr_d;
  logic [IDX_W-1:0]              win_q, win_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [MEMI_ADDR_WIDTH-1:0]    memi_addr_q, memi_addr_d;
  logic [MEMI_NR_SLAVES-1:0]     memi_sel_q, memi_sel_d;
  logic                          memi_wr_rd_q, memi_wr_rd_d;
  logic [MEMI_WDATA_WIDTH-1:0]   memi_wdata_q, memi_wdata_d;
  logic [NR_REQ-1:0]             req_ack_q, req_ack_d;
  logic [NR_REQ-1:0]             req_err_q, req_err_d;
  logic [MEMI_RDATA_WIDTH-1:0]   req_rdata_q, req_rdata_d;

  logic                          found;
  logic [IDX_W-1:0]              pick;
  int                            cand;

  // Cyclic search starting just after the last winner gives round-robin fairness.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = 0;
    for (int k = 1; k <= NR_REQ; k++) begin
      cand = (int'(ptr_q) + k) % NR_REQ;
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    cnt_d        = cnt_q;
    memi_addr_d  = memi_addr_q;
    memi_sel_d   = memi_sel_q;
    memi_wr_rd_d = memi_wr_rd_q;
    memi_wdata_d = memi_wdata_q;
    req_rdata_d  = req_rdata_q;
    req_ack_d    = '0;
    req_err_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          memi_addr_d  = req_addr[int'(pick)*MEMI_ADDR_WIDTH +: MEMI_ADDR_WIDTH];
          memi_sel_d   = req_sel[int'(pick)*MEMI_NR_SLAVES +: MEMI_NR_SLAVES];
          memi_wr_rd_d = req_wr_rd[pick];
          memi_wdata_d = req_wdata[int'(pick)*MEMI_WDATA_WIDTH +: MEMI_WDATA_WIDTH];
          win_d        = pick;
          ptr_d        = pick;
          cnt_d        = '0;
          state_d      = S_BUSY;
        end
      end
      S_BUSY: begin
        // Ready takes precedence over a timeout landing on the same edge.
        if (memi_ready) begin
          memi_sel_d       = '0;
          req_ack_d[win_q] = 1'b1;
          if (!memi_wr_rd_q) begin
            req_rdata_d = memi_rdata;
          end
          state_d = S_IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          memi_sel_d       = '0;
          req_err_d[win_q] = 1'b1;
          state_d          = S_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge memi_clk or negedge memi_rst) begin
    if (!memi_rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= PTR_RST;
      win_q        <= '0;
      cnt_q        <= '0;
      memi_addr_q  <= '0;
      memi_sel_q   <= '0;
      memi_wr_rd_q <= 1'b0;
      memi_wdata_q <= '0;
      req_ack_q    <= '0;
      req_err_q    <= '0;
      req_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      memi_addr_q  <= memi_addr_d;
      memi_sel_q   <= memi_sel_d;
      memi_wr_rd_q <= memi_wr_rd_d;
      memi_wdata_q <= memi_wdata_d;
      req_ack_q    <= req_ack_d;
      req_err_q    <= req_err_d;
      req_rdata_q  <= req_rdata_d;
    end
  end

  assign busy       = (state_q == S_BUSY);
  assign memi_addr  = memi_addr_q;
  assign memi_sel   = memi_sel_q;
  assign memi_wr_rd = memi_wr_rd_q;
  assign memi_wdata = memi_wdata_q;
  assign req_ack    = req_ack_q;
  assign req_err    = req_err_q;
  assign req_rdata  = req_rdata_q;

endmodule

// File: tb/tb_memi_arbiter.sv
// Scoreboard bench for memi_arbiter: a transaction-level model predicts grants, completions and timing.
module tb_memi_arbiter;
  localparam int NR    = 2;
  localparam int NS    = 1;
  localparam int AW    = 5;
  localparam int WW    = 32;
  localparam int RW    = 32;
  localparam int TO    = 4;
  localparam int NEVER = 1000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*NS-1:0]  req_sel;
  logic [NR-1:0]     req_wr_rd;
  logic [NR*WW-1:0]  req_wdata;
  logic [NR-1:0]     req_ack;
  logic [NR-1:0]     req_err;
  logic [RW-1:0]     req_rdata;
  logic              busy;
  logic [AW-1:0]     memi_addr;
  logic [NS-1:0]     memi_sel;
  logic              memi_wr_rd;
  logic [WW-1:0]     memi_wdata;
  logic [RW-1:0]     memi_rdata;
  logic              memi_ready;

  always #5 clk = ~clk;

  memi_arbiter #(
    .NR_REQ(NR), .MEMI_NR_SLAVES(NS), .MEMI_ADDR_WIDTH(AW),
    .MEMI_WDATA_WIDTH(WW), .MEMI_RDATA_WIDTH(RW), .TIMEOUT(TO)
  ) dut (
    .memi_clk(clk), .memi_rst(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_sel(req_sel),
    .req_wr_rd(req_wr_rd), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_err(req_err), .req_rdata(req_rdata), .busy(busy),
    .memi_addr(memi_addr), .memi_sel(memi_sel), .memi_wr_rd(memi_wr_rd),
    .memi_wdata(memi_wdata), .memi_rdata(memi_rdata), .memi_ready(memi_ready)
  );

  typedef struct {
    logic [NR-1:0] ack;
    logic [NR-1:0] err;
    int            cyc;
  } txn_t;

  typedef struct {
    logic          busy;
    logic [NS-1:0] sel;
    logic [AW-1:0] addr;
    logic          wr;
    logic [WW-1:0] wdata;
    logic [RW-1:0] rdata;
  } cyc_t;

  txn_t txn_q[$];
  cyc_t cyc_q[$];

  // Reference model state (owned by the stimulus process)
  int            cyc = 0;
  bit            m_busy;
  bit            m_err;
  int            m_win, m_ptr, m_g, m_d, m_end;
  logic [AW-1:0] m_addr;
  logic [NS-1:0] m_sel;
  logic          m_wr;
  logic [WW-1:0] m_wdata;
  logic [RW-1:0] m_rdata, m_plan_rdata;
  bit            own [NR];
  bit            auto_req, stray_en, force_rd_en;
  logic [NR-1:0] keep_req;
  int            force_d;
  logic [RW-1:0] force_rd;

  // Checking counters (owned by the monitor process)
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc_t c;
    txn_t t;
    if (cyc_q.size() != 0) begin
      c = cyc_q.pop_front();
      chk("memi_sel", 64'(memi_sel), 64'(c.sel));
      chk("busy", 64'(busy), 64'(c.busy));
      chk("req_rdata", 64'(req_rdata), 64'(c.rdata));
      if (c.busy) begin
        chk("memi_addr", 64'(memi_addr), 64'(c.addr));
        chk("memi_wr_rd", 64'(memi_wr_rd), 64'(c.wr));
        chk("memi_wdata", 64'(memi_wdata), 64'(c.wdata));
      end
    end
    if ((req_ack | req_err) != '0) begin
      if (txn_q.size() == 0) begin
        chk("unexpected_resp", 64'({req_ack, req_err}), 64'd0);
      end else begin
        t = txn_q.pop_front();
        chk("req_ack", 64'(req_ack), 64'(t.ack));
        chk("req_err", 64'(req_err), 64'(t.err));
        chk("resp_cycle", 64'(cyc), 64'(t.cyc));
      end
    end else if (txn_q.size() != 0 && txn_q[0].cyc <= cyc) begin
      t = txn_q.pop_front();
      chk("missing_ack", 64'(req_ack), 64'(t.ack));
      chk("missing_err", 64'(req_err), 64'(t.err));
    end
  end

  task automatic model_reset();
    m_busy  = 1'b0;
    m_ptr   = NR - 1;
    m_rdata = '0;
    txn_q.delete();
    for (int i = 0; i < NR; i++) begin
      own[i]       = 1'b0;
      req_valid[i] = 1'b0;
    end
  endtask

  function automatic int rand_delay();
    case ($urandom_range(0, 7))
      0, 1, 2: return 1;
      3:       return 2;
      4:       return 3;
      5:       return TO;
      6:       return TO + 1;
      default: return NEVER;
    endcase
  endfunction

  // Applies the arbiter's rules to the inputs present at the edge just taken.
  task automatic model_edge();
    txn_t t;
    int   w;
    if (m_busy) begin
      if (cyc == m_end) begin
        m_busy     = 1'b0;
        own[m_win] = 1'b0;
        if (!m_err && !m_wr) m_rdata = m_plan_rdata;
      end
    end else begin
      w = -1;
      for (int k = 1; k <= NR; k++) begin
        if (w < 0 && req_valid[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
      end
      if (w >= 0) begin
        m_busy  = 1'b1;
        m_win   = w;
        m_ptr   = w;
        m_g     = cyc;
        m_addr  = req_addr[w*AW +: AW];
        m_sel   = req_sel[w*NS +: NS];
        m_wr    = req_wr_rd[w];
        m_wdata = req_wdata[w*WW +: WW];
        m_d     = (force_d >= 0) ? force_d : rand_delay();
        if (m_sel == '0) m_d = NEVER;
        m_plan_rdata = force_rd_en ? force_rd : RW'($urandom);
        m_err = (m_d > TO);
        m_end = m_err ? cyc + TO : cyc + m_d;
        t.ack = m_err ? '0 : NR'(1) << w;
        t.err = m_err ? NR'(1) << w : '0;
        t.cyc = m_end;
        txn_q.push_back(t);
      end
    end
  endtask

  task automatic rand_payload(input int i);
    req_addr[i*AW +: AW]  = AW'($urandom);
    req_sel[i*NS +: NS]   = ($urandom_range(0, 5) == 0) ? NS'(0) : NS'(1);
    req_wr_rd[i]          = 1'($urandom_range(0, 1));
    req_wdata[i*WW +: WW] = WW'($urandom);
  endtask

  task automatic present(input int i, input logic [AW-1:0] a, input logic [NS-1:0] s,
                         input logic wr, input logic [WW-1:0] wd);
    req_addr[i*AW +: AW]  = a;
    req_sel[i*NS +: NS]   = s;
    req_wr_rd[i]          = wr;
    req_wdata[i*WW +: WW] = wd;
    own[i]                = 1'b1;
    req_valid[i]          = 1'b1;
  endtask

  task automatic drive_next();
    memi_ready = 1'b0;
    memi_rdata = RW'($urandom);
    if (m_busy && (cyc + 1 == m_g + m_d)) begin
      memi_ready = 1'b1;
      memi_rdata = m_plan_rdata;
    end else if (!m_busy && stray_en && $urandom_range(0, 3) == 0) begin
      memi_ready = 1'b1;
    end
    for (int i = 0; i < NR; i++) begin
      if (!own[i]) begin
        if (auto_req ? ($urandom_range(0, 2) != 0) : keep_req[i]) begin
          own[i]       = 1'b1;
          req_valid[i] = 1'b1;
          if (auto_req) rand_payload(i);
        end else begin
          req_valid[i] = 1'b0;
        end
      end else if (auto_req && m_busy && m_win == i) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
      end else if (auto_req && $urandom_range(0, 9) == 0) begin
        own[i]       = 1'b0;
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic cyc_push();
    cyc_t c;
    c.busy  = m_busy;
    c.sel   = m_busy ? m_sel : '0;
    c.addr  = m_addr;
    c.wr    = m_wr;
    c.wdata = m_wdata;
    c.rdata = m_rdata;
    cyc_q.push_back(c);
  endtask

  task automatic step(input bit rst_now, input bit rst_rel);
    @(posedge clk);
    cyc++;
    if (rst_n) model_edge();
    #2;
    if (rst_now) begin
      rst_n = 1'b0;
      model_reset();
    end
    if (rst_rel) rst_n = 1'b1;
    cyc_push();
    drive_next();
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && (m_busy || own[0] || own[1]); n++) step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b1;
    req_valid = '0; req_addr = '0; req_sel = '0; req_wr_rd = '0; req_wdata = '0;
    memi_ready = 1'b0; memi_rdata = '0;
    auto_req = 1'b0; stray_en = 1'b0; force_rd_en = 1'b0; keep_req = '0;
    force_d = -1; force_rd = '0;
    m_addr = '0; m_sel = '0; m_wr = 1'b0; m_wdata = '0; m_plan_rdata = '0;
    m_win = 0; m_g = 0; m_d = 0; m_end = 0; m_err = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;

    // Reset state, then stray ready pulses while idle
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    stray_en = 1'b1;
    repeat (6) step(1'b0, 1'b0);
    stray_en = 1'b0;

    // Single read: ready three edges after grant, known read data
    force_d = 3; force_rd_en = 1'b1; force_rd = 32'hDEADBEEF;
    present(0, 5'h03, 1'b1, 1'b0, '0);
    drain();

    // Contention with fast slave responses: grants alternate
    force_d = 1; force_rd = 32'h12345678;
    present(0, 5'h0A, 1'b1, 1'b1, 32'hA5A5_0000);
    present(1, 5'h15, 1'b1, 1'b0, 32'h0000_5A5A);
    keep_req = 2'b11;
    repeat (16) step(1'b0, 1'b0);
    keep_req = 2'b00;
    drain();

    // Slave never ready: both requests time out in turn
    force_d = NEVER;
    present(0, 5'h01, 1'b1, 1'b0, '0);
    present(1, 5'h02, 1'b1, 1'b1, 32'hCAFE);
    drain();

    // Ready on the same edge the timeout would fire
    force_d = TO; force_rd = 32'h0BADF00D;
    present(0, 5'h1F, 1'b1, 1'b0, '0);
    drain();

    // Reset while requester 1 holds the grant
    force_d = 3; keep_req = 2'b11;
    present(0, 5'h04, 1'b1, 1'b0, '0);
    present(1, 5'h08, 1'b1, 1'b1, 32'h1111);
    for (int n = 0; n < 40 && !(m_busy && m_win == 1); n++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (12) step(1'b0, 1'b0);
    keep_req = 2'b00;
    drain();

    // Randomized traffic with occasional resets
    auto_req = 1'b1; stray_en = 1'b1; force_rd_en = 1'b0; force_d = -1;
    for (int n = 0; n < 1500; n++) begin
      if (!rst_n) step(1'b0, 1'b1);
      else if ($urandom_range(0, 199) == 0) step(1'b1, 1'b0);
      else step(1'b0, 1'b0);
    end
    if (!rst_n) step(1'b0, 1'b1);
    auto_req = 1'b0; stray_en = 1'b0; force_d = 1;
    drain();
    repeat (2) step(1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
